result_sram_reader: RTL and testbench
=====================================

# result_sram_reader

Read-back engine for the interpolated output image held in ResultSRAM. After the scaler asserts its completion flag, it sweeps the TW×TH result window in raster order. Each read pixel leaves on a valid/ready stream tagged with its (x, y) coordinate and a last-pixel marker. It feeds the display/compare path and is the reading end of the SRAM the scaler writes.

## Interface
Parameters:
- AW, 14, SRAM address width.
- DW, 8, pixel width.
- FIFO_DEPTH, 4, output buffer entries; legal range is 2 or more, power of two.

Ports:
- CLK  in  1  sole clock; all flops rise-edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; starts a sweep; sampled only in IDLE.
- TW  in  6  target width, latched at START.
- TH  in  6  target height, latched at START.
- SRAM_Q  in  DW  ResultSRAM read data.
- SRAM_CEN  out  1  ResultSRAM chip enable, active low.
- SRAM_WEN  out  1  ResultSRAM write enable, active low; constant 1.
- SRAM_A  out  AW  ResultSRAM address.
- PIX_VALID  out  1  stream valid.
- PIX_READY  in  1  stream ready.
- PIX_DATA  out  DW  pixel value.
- PIX_X  out  6  column of the current pixel.
- PIX_Y  out  6  row of the current pixel.
- PIX_LAST  out  1  high with the pixel at (TW-1, TH-1).
- BUSY  out  1  high from START acceptance until the DONE cycle, inclusive.
- DONE  out  1  one-cycle pulse when the last pixel handshakes.
- CHECKSUM  out  16  running sum of popped pixels (see Configuration).

## Operation
- Reset (async) values:
  - SRAM_CEN=1, SRAM_WEN=1, SRAM_A=0.
  - PIX_VALID=0, PIX_DATA=0, PIX_X=0, PIX_Y=0, PIX_LAST=0.
  - BUSY=0, DONE=0, CHECKSUM=0.
  - FIFO emptied, in-flight flag cleared, state IDLE.
- States: IDLE → RUN → FIN → IDLE.
  - IDLE: on START, latch TW/TH, clear address, coordinates and CHECKSUM.
    - Go to RUN.
    - If TW==0 or TH==0, go to FIN directly; no reads are issued.
  - RUN: issue at most one read per cycle, combinationally.
    - Issue condition: SRAM_CEN=0 while issued < TW*TH and (occupancy + inflight − pop_this_cycle) < FIFO_DEPTH.
    - SRAM_A = linear address = y*TW + x, starting at 0, incrementing by 1.
    - Issue coordinates advance: x wraps at TW-1 to 0 and y increments.
  - RUN → FIN when the handshake of the PIX_LAST pixel completes.
  - FIN: DONE=1 for one cycle, BUSY still 1; next state is IDLE.
- Read return: SRAM_Q is valid the cycle after issue. It is written into the FIFO at the end of that cycle together with its x, y and last flag.
- Stream rules:
  - PIX_* fields show the FIFO head whenever it is non-empty.
  - Once PIX_VALID=1, the head and all fields stay stable until PIX_READY=1.
  - A pop and a push in the same cycle are both honoured; occupancy stays unchanged.
  - FIFO never overflows; the credit check above guarantees this.
- START while BUSY=1 is ignored.
- Reset mid-sweep aborts immediately. Outputs return to reset values and no further SRAM access occurs.
- Arithmetic: TW*TH computed as 12-bit; linear address zero-extended to AW. Max window is 63×63 = 3969, which is below 2^AW.

## Timing
- START sampled at edge e0; the first issue cycle is the cycle after e0.
- Issue in cycle n → PIX_VALID=1 in cycle n+2 (FIFO empty before).
- With PIX_READY held 1: sustained throughput is 1 pixel/cycle.
  - Total sweep is TW*TH+3 cycles from START to the DONE cycle.
- PIX_READY low stalls issue after FIFO_DEPTH outstanding entries; no data lost.
- DONE asserts in the cycle after the final handshake; BUSY deasserts in the cycle after DONE.

## Configuration
- Macro RESULT_READER_CHECKSUM_EN.
- Defined: CHECKSUM holds a 16-bit sum of every handshaken PIX_DATA, wrapping modulo 2^16.
  - It updates the cycle after each pop, is cleared on START, and holds after DONE.
- Undefined: no adder or register is built; CHECKSUM is tied to 0.

## Test plan
- Full throughput: TW=4, TH=3, SRAM preloaded with mem[i]=i, READY=1.
  - Expect 12 pixels 0..11 on consecutive cycles.
  - Expect PIX_X/PIX_Y in raster order, PIX_LAST only on (3,2), DONE 15 cycles after START.
- Backpressure: same image with READY toggling 1,0,0,1 repeating.
  - Expect identical data sequence and fields stable while stalled.
  - Expect at most FIFO_DEPTH reads outstanding, SRAM_CEN high while full.
- Checksum (macro on): TW=TH=2, mem = 200,100,50,255.
  - Expect CHECKSUM=605 after DONE. With the macro off, expect CHECKSUM=0.
- Degenerate: TW=0, TH=5.
  - Expect no SRAM_CEN low, no PIX_VALID, DONE one cycle after START.
  - With TW=TH=1, expect a single pixel with PIX_LAST=1.
- Reset mid-sweep: assert RST after 5 pixels of a 6×6 sweep.
  - Expect all outputs at reset values immediately and FIFO empty.
  - A new START then produces the full 36-pixel sequence from address 0.
- START during BUSY: pulse START again mid-sweep with different TW/TH.
  - Expect it ignored; the sweep completes with the original dimensions.

Source files
------------

// File: rtl/result_sram_reader.sv
// Raster read-back of the scaler result window into a tagged valid/ready pixel stream.
// Optional running checksum of streamed pixels is built only with RESULT_READER_CHECKSUM_EN.
module result_sram_reader #(
  parameter int AW         = 14,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [5:0]    TW,
  input  logic [5:0]    TH,
  input  logic [DW-1:0] SRAM_Q,
  output logic          SRAM_CEN,
  output logic          SRAM_WEN,
  output logic [AW-1:0] SRAM_A,
  output logic          PIX_VALID,
  input  logic          PIX_READY,
  output logic [DW-1:0] PIX_DATA,
  output logic [5:0]    PIX_X,
  output logic [5:0]    PIX_Y,
  output logic          PIX_LAST,
  output logic          BUSY,
  output logic          DONE,
  output logic [15:0]   CHECKSUM
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;

  logic [5:0]    tw_r, th_r, ix, iy;
  logic [11:0]   issued, total;
  logic          busy, done;
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [5:0]    fifo_x    [FIFO_DEPTH];
  logic [5:0]    fifo_y    [FIFO_DEPTH];
  logic          fifo_last [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          inflight, fl_last;
  logic [5:0]    fl_x, fl_y;
  logic          pop, push, issue;
  logic [CW-1:0] credit;

  assign total  = 12'(tw_r) * 12'(th_r);
  assign pop    = PIX_VALID & PIX_READY;
  assign push   = inflight;
  // Slots already promised: stored entries plus the read returning now, minus what leaves now.
  assign credit = CW'(count) + CW'(inflight) - CW'(pop);
  assign issue  = (state == RUN) && (issued < total) && (credit < CW'(FIFO_DEPTH));

  assign SRAM_CEN  = ~issue;
  assign SRAM_WEN  = 1'b1;
  assign SRAM_A    = AW'(issued);
  assign PIX_VALID = (count != '0);
  assign PIX_DATA  = fifo_data[rd_ptr];
  assign PIX_X     = fifo_x[rd_ptr];
  assign PIX_Y     = fifo_y[rd_ptr];
  assign PIX_LAST  = PIX_VALID & fifo_last[rd_ptr];
  assign BUSY      = busy;
  assign DONE      = done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      tw_r   <= '0;
      th_r   <= '0;
      ix     <= '0;
      iy     <= '0;
      issued <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            tw_r   <= TW;
            th_r   <= TH;
            ix     <= '0;
            iy     <= '0;
            issued <= '0;
            busy   <= 1'b1;
            if (TW == 6'd0 || TH == 6'd0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            issued <= issued + 12'd1;
            if (ix == tw_r - 6'd1) begin
              ix <= '0;
              iy <= iy + 6'd1;
            end else begin
              ix <= ix + 6'd1;
            end
          end
          if (pop && PIX_LAST) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      fl_x     <= '0;
      fl_y     <= '0;
      fl_last  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_x[i]    <= '0;
        fifo_y[i]    <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        fl_x    <= ix;
        fl_y    <= iy;
        fl_last <= (issued == total - 12'd1);
      end
      if (push) begin
        fifo_data[wr_ptr] <= SRAM_Q;
        fifo_x[wr_ptr]    <= fl_x;
        fifo_y[wr_ptr]    <= fl_y;
        fifo_last[wr_ptr] <= fl_last;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

`ifdef RESULT_READER_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      csum <= '0;
    end else if (state == IDLE && START) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum + 16'(PIX_DATA);
    end
  end

  assign CHECKSUM = csum;
`else
  assign CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_result_sram_reader.sv
// Bench for result_sram_reader: vector table of sweeps, hand sequences for reset/restart, random sweeps.
// The expected pixel stream is rebuilt from window dimensions and memory contents.
module tb_result_sram_reader;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int FIFO_DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST, START, PIX_READY;
  logic [5:0]    TW, TH;
  logic [DW-1:0] SRAM_Q;
  logic          SRAM_CEN, SRAM_WEN;
  logic [AW-1:0] SRAM_A;
  logic          PIX_VALID, PIX_LAST, BUSY, DONE;
  logic [DW-1:0] PIX_DATA;
  logic [5:0]    PIX_X, PIX_Y;
  logic [15:0]   CHECKSUM;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:(1<<AW)-1];

  typedef struct {
    logic [7:0] d;
    logic [5:0] x;
    logic [5:0] y;
    logic       last;
  } pix_t;

  typedef struct {
    int tw;
    int th;
    int mem_mode;
    int rmode;
    int restart_at;
    int abort_after;
    int exp_done;
    int exp_csum;
  } vec_t;

  vec_t vecs[10];

  result_sram_reader #(.AW(AW), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .TW(TW), .TH(TH), .SRAM_Q(SRAM_Q),
    .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_DATA(PIX_DATA),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_LAST(PIX_LAST),
    .BUSY(BUSY), .DONE(DONE), .CHECKSUM(CHECKSUM)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!SRAM_CEN) SRAM_Q <= mem[SRAM_A];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not match the expected sequence", name);
  endtask

  task automatic check_reset_values();
    check("rst_cen", SRAM_CEN, 1);
    check("rst_wen", SRAM_WEN, 1);
    check("rst_addr", SRAM_A, 0);
    check("rst_valid", PIX_VALID, 0);
    check("rst_data", PIX_DATA, 0);
    check("rst_x", PIX_X, 0);
    check("rst_y", PIX_Y, 0);
    check("rst_last", PIX_LAST, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_checksum", CHECKSUM, 0);
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 4096; i++) begin
      case (mode)
        0:       mem[i] = 8'(i);
        1:       mem[i] = (i == 0) ? 8'd200 : (i == 1) ? 8'd100 : (i == 2) ? 8'd50 : (i == 3) ? 8'd255 : 8'd0;
        default: mem[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic run_sweep(input int tw, input int th, input int rmode, input int restart_at,
                           input int abort_after, input int exp_done, input int exp_csum);
    pix_t q[$];
    pix_t h, prev;
    int n, issues, pops, first_valid, last_pop, done_at, budget, sum;
    logic prev_stall;
    n = tw * th;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      h.d = mem[i];
      h.x = 6'(i % tw);
      h.y = 6'(i / tw);
      h.last = (i == n - 1);
      q.push_back(h);
      sum += int'(mem[i]);
    end
    @(negedge CLK);
    START = 1'b1;
    TW = 6'(tw);
    TH = 6'(th);
    PIX_READY = 1'b1;
    issues = 0; pops = 0; first_valid = -1; last_pop = -1; done_at = -1;
    prev_stall = 1'b0;
    prev = '{default: '0};
    budget = n * 10 + 20;
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLK);
      START = (k == restart_at);
      if (k == restart_at) begin
        TW = 6'd7;
        TH = 6'd2;
      end
      case (rmode)
        0:       PIX_READY = 1'b1;
        1:       PIX_READY = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
        default: PIX_READY = 1'($urandom % 2);
      endcase
      #1;
      if (prev_stall) begin
        check("stall_valid", PIX_VALID, 1);
        check("stall_data", PIX_DATA, prev.d);
        check("stall_x", PIX_X, prev.x);
        check("stall_y", PIX_Y, prev.y);
        check("stall_last", PIX_LAST, prev.last);
      end
      check("busy_during_sweep", BUSY, 1);
      check("wen_const", SRAM_WEN, 1);
      if (!SRAM_CEN) begin
        check("sram_addr", SRAM_A, issues);
        issues++;
      end
      if (PIX_VALID && first_valid < 0) begin
        first_valid = k;
        if (n > 0) check("first_valid_cycle", k, 3);
      end
      if (PIX_VALID && PIX_READY) begin
        if (q.size() == 0) begin
          fail_now("extra_pixel");
        end else begin
          h = q.pop_front();
          check("pix_data", PIX_DATA, h.d);
          check("pix_x", PIX_X, h.x);
          check("pix_y", PIX_Y, h.y);
          check("pix_last", PIX_LAST, h.last);
        end
        pops++;
        last_pop = k;
      end
      check("outstanding_le_depth", (issues - pops) <= FIFO_DEPTH, 1);
      if (abort_after > 0 && pops == abort_after) begin
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_reset_values();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("abort_cen_idle", SRAM_CEN, 1);
        check("abort_valid_idle", PIX_VALID, 0);
        @(negedge CLK);
        #1;
        check("abort_cen_later", SRAM_CEN, 1);
        check("abort_busy_later", BUSY, 0);
        return;
      end
      if (DONE) begin
        done_at = k;
        break;
      end
      prev_stall = PIX_VALID && !PIX_READY;
      prev.d = PIX_DATA;
      prev.x = PIX_X;
      prev.y = PIX_Y;
      prev.last = PIX_LAST;
    end
    START = 1'b0;
    if (done_at < 0) begin
      fail_now("done_timeout");
      return;
    end
    if (exp_done >= 0) check("done_cycle", done_at, exp_done);
    if (n > 0) check("done_after_last", done_at, last_pop + 1);
    else check("no_valid_degenerate", first_valid, -1);
    check("pixels_left", q.size(), 0);
    check("issues_total", issues, n);
    @(negedge CLK);
    #1;
    check("busy_after_done", BUSY, 0);
    check("done_one_cycle", DONE, 0);
`ifdef RESULT_READER_CHECKSUM_EN
    check("checksum_model", CHECKSUM, sum & 32'hFFFF);
    if (exp_csum >= 0) check("checksum_const", CHECKSUM, exp_csum);
`else
    check("checksum_off", CHECKSUM, 0);
`endif
    @(negedge CLK);
    #1;
`ifdef RESULT_READER_CHECKSUM_EN
    check("checksum_hold", CHECKSUM, sum & 32'hFFFF);
`else
    check("checksum_off_hold", CHECKSUM, 0);
`endif
  endtask

  initial begin
    vecs[0] = '{4, 3, 0, 0, 0, 0, 15, -1};
    vecs[1] = '{4, 3, 0, 1, 0, 0, -1, -1};
    vecs[2] = '{2, 2, 1, 0, 0, 0, 7, 605};
    vecs[3] = '{0, 5, 0, 0, 0, 0, 1, -1};
    vecs[4] = '{1, 1, 0, 0, 0, 0, 4, -1};
    vecs[5] = '{6, 6, 0, 0, 0, 5, -1, -1};
    vecs[6] = '{6, 6, 0, 0, 0, 0, 39, -1};
    vecs[7] = '{4, 3, 0, 0, 6, 0, 15, -1};
    vecs[8] = '{5, 0, 0, 0, 0, 0, 1, -1};
    vecs[9] = '{63, 2, 2, 1, 0, 0, -1, -1};

    RST = 1'b1;
    START = 1'b0;
    TW = '0;
    TH = '0;
    PIX_READY = 1'b0;
    fill_mem(0);
    repeat (2) @(negedge CLK);
    #1;
    check_reset_values();
    @(negedge CLK);
    RST = 1'b0;

    for (int v = 0; v < 10; v++) begin
      fill_mem(vecs[v].mem_mode);
      run_sweep(vecs[v].tw, vecs[v].th, vecs[v].rmode, vecs[v].restart_at,
                vecs[v].abort_after, vecs[v].exp_done, vecs[v].exp_csum);
    end

    for (int r = 0; r < 8; r++) begin
      int tw, th, n;
      tw = int'($urandom_range(0, 9));
      th = int'($urandom_range(1, 7));
      n = tw * th;
      fill_mem(2);
      if (r % 2 == 0) run_sweep(tw, th, 2, 0, 0, -1, -1);
      else run_sweep(tw, th, 0, 0, 0, (n == 0) ? 1 : n + 3, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
